// File: rtl/run_seq_pkg.sv
// ---------------------------------------------------------------------------
// run_seq_pkg
// Shared types and constants for the run sequencer.
//   state_t : sequencer FSM states
//   ADDR_W  : data-memory address width (8 bits, wraps 255 -> 0)
//   DATA_W  : data-memory byte width
// ---------------------------------------------------------------------------
package run_seq_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

endpackage

// File: rtl/run_sequencer_counter.sv
// ---------------------------------------------------------------------------
// seq_counter
// Saturating up-counter with synchronous clear and count enable.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset (count -> 0)
//   clr    in  synchronous clear, has priority over en
//   en     in  count enable; the count sticks at all-ones
//   count  out current count
// ---------------------------------------------------------------------------
module seq_counter #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/run_sequencer.sv
// ---------------------------------------------------------------------------
// run_sequencer
// Drives a complete program run of the processor core: preloads data memory
// from a byte stream, pulses the core start, counts cycles until done, then
// streams a result window of data memory back out.
//
// Optional feature: define RUN_SEQUENCER_TIMEOUT_EN to add the RUN watchdog,
// the TIMEOUT_CYCLES parameter and the sticky timeout output.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   go                    start a run; only looked at in IDLE
//   in_valid/in_data/     preload byte stream (valid/ready)
//   in_ready
//   mem_wr_en/mem_addr/   data-memory write port and shared address;
//   mem_wr_data/          mem_rd_data is a combinational read of mem_addr
//   mem_rd_data
//   cpu_start             held high START_CYCLES cycles (core reset/start)
//   cpu_done              core completion
//   out_valid/out_data/   result byte stream (valid/ready)
//   out_ready
//   busy                  high whenever not IDLE
//   cycle_count           RUN cycles of the last run, held until next go
//   finished              one-cycle pulse on the return to IDLE
//   timeout               (feature only) run abandoned by the watchdog
//   fsm_state             current FSM state, for observation
//
// Handshakes: a byte moves on a rising edge where valid && ready are both
// high. in_ready is high only in LOAD and does not depend on in_valid;
// out_valid is high only in DRAIN, and while out_ready is low the address
// and data presented are held stable.
// ---------------------------------------------------------------------------
module run_sequencer
   import run_seq_pkg::*;
#(
   parameter int          LOAD_BASE    = 0,
   parameter int          LOAD_LEN     = 64,
   parameter int          RES_BASE     = 64,
   parameter int          RES_LEN      = 64,
   parameter int          START_CYCLES = 2,
   parameter int          CNT_W        = 24
`ifdef RUN_SEQUENCER_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              cpu_start,
   input  logic              cpu_done,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              finished,
`ifdef RUN_SEQUENCER_TIMEOUT_EN
   output logic              timeout,
`endif
   output state_t            fsm_state
);

   // Start-pulse counter only needs to reach START_CYCLES-1.
   localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

   localparam logic [ADDR_W-1:0] LOAD_BASE_A = ADDR_W'(LOAD_BASE);
   localparam logic [ADDR_W-1:0] RES_BASE_A  = ADDR_W'(RES_BASE);
   localparam logic [ADDR_W-1:0] LOAD_LAST   = ADDR_W'(LOAD_LEN - 1);
   localparam logic [ADDR_W-1:0] RES_LAST    = ADDR_W'(RES_LEN - 1);
   localparam logic [SC_W-1:0]   START_LAST  = SC_W'(START_CYCLES - 1);

`ifdef RUN_SEQUENCER_TIMEOUT_EN
   // The watchdog fires on the RUN cycle that brings the count to the limit.
   localparam logic [CNT_W-1:0]  TIMEOUT_M1  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   state_t            state, state_next;
   logic [ADDR_W-1:0] idx, idx_next;
   logic [SC_W-1:0]   start_cnt, start_cnt_next;
   logic              run_first, run_first_next;
   logic              finished_next;
   logic              cnt_clr, cnt_en;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
   logic              timeout_next;
`endif

   // ------------------------------------------------------------------------
   // Cycle counter: cleared on go, advanced on every RUN cycle (including the
   // cycle in which done is accepted).
   // ------------------------------------------------------------------------
   seq_counter #(
      .W (CNT_W)
   ) u_cycle_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .count (cycle_count)
   );

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         idx       <= '0;
         start_cnt <= '0;
         run_first <= 1'b0;
         finished  <= 1'b0;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
         timeout   <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         idx       <= idx_next;
         start_cnt <= start_cnt_next;
         run_first <= run_first_next;
         finished  <= finished_next;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
         timeout   <= timeout_next;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------------
   always_comb begin
      state_next     = state;
      idx_next       = idx;
      start_cnt_next = start_cnt;
      run_first_next = run_first;
      finished_next  = 1'b0;
      cnt_clr        = 1'b0;
      cnt_en         = 1'b0;
      in_ready       = 1'b0;
      mem_wr_en      = 1'b0;
      mem_addr       = '0;
      mem_wr_data    = '0;
      cpu_start      = 1'b0;
      out_valid      = 1'b0;
      out_data       = '0;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
      timeout_next   = timeout;
`endif

      case (state)
         S_IDLE: begin
            if (go) begin
               state_next = S_LOAD;
               idx_next   = '0;
               cnt_clr    = 1'b1;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
               timeout_next = 1'b0;
`endif
            end
         end

         S_LOAD: begin
            in_ready = 1'b1;
            mem_addr = LOAD_BASE_A + idx;
            if (in_valid) begin
               // Write goes out in the same cycle as the handshake.
               mem_wr_en   = 1'b1;
               mem_wr_data = in_data;
               if (idx == LOAD_LAST) begin
                  state_next     = S_START;
                  idx_next       = '0;
                  start_cnt_next = '0;
               end else begin
                  idx_next = idx + ADDR_W'(1);
               end
            end
         end

         S_START: begin
            cpu_start = 1'b1;
            if (start_cnt == START_LAST) begin
               state_next     = S_RUN;
               run_first_next = 1'b1;
            end else begin
               start_cnt_next = start_cnt + SC_W'(1);
            end
         end

         S_RUN: begin
            cnt_en         = 1'b1;
            run_first_next = 1'b0;
            // On the first RUN cycle cpu_done may still be the previous
            // run's level, so it is not trusted until the core has restarted.
            if (!run_first && cpu_done) begin
               state_next = S_DRAIN;
               idx_next   = '0;
            end
`ifdef RUN_SEQUENCER_TIMEOUT_EN
            else if (cycle_count == TIMEOUT_M1) begin
               state_next    = S_IDLE;
               timeout_next  = 1'b1;
               finished_next = 1'b1;
            end
`endif
         end

         S_DRAIN: begin
            out_valid = 1'b1;
            mem_addr  = RES_BASE_A + idx;
            out_data  = mem_rd_data;
            if (out_ready) begin
               if (idx == RES_LAST) begin
                  state_next    = S_IDLE;
                  idx_next      = '0;
                  finished_next = 1'b1;
               end else begin
                  idx_next = idx + ADDR_W'(1);
               end
            end
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign fsm_state = state;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;
  import run_seq_pkg::*;

  localparam int LOAD_BASE    = 0;
  localparam int LOAD_LEN     = 64;
  localparam int RES_BASE     = 64;
  localparam int RES_LEN      = 64;
  localparam int START_CYCLES = 2;
  localparam int CNT_W        = 24;
  localparam int TO_CYCLES    = 50;

  // --------------------------------------------------------------------------
  // Clock / reset and DUT
  // --------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset;
  logic             go, in_valid, in_ready, mem_wr_en, cpu_start, cpu_done;
  logic             out_valid, out_ready, busy, finished;
  logic [7:0]       in_data, mem_addr, mem_wr_data, mem_rd_data, out_data;
  logic [CNT_W-1:0] cycle_count;
  state_t           fsm_state;
`ifdef RUN_SEQUENCER_TIMEOUT_EN
  logic             timeout;
`endif

  always #5 clk = ~clk;

  run_sequencer #(
    .LOAD_BASE    (LOAD_BASE),
    .LOAD_LEN     (LOAD_LEN),
    .RES_BASE     (RES_BASE),
    .RES_LEN      (RES_LEN),
    .START_CYCLES (START_CYCLES),
    .CNT_W        (CNT_W)
`ifdef RUN_SEQUENCER_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO_CYCLES)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data),
    .cpu_start   (cpu_start),
    .cpu_done    (cpu_done),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .cycle_count (cycle_count),
    .finished    (finished),
`ifdef RUN_SEQUENCER_TIMEOUT_EN
    .timeout     (timeout),
`endif
    .fsm_state   (fsm_state)
  );

  // Data memory attached to the sequencer (combinational read).
  logic [7:0] mem [256];
  assign mem_rd_data = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] = mem_wr_data;

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [15:0] exp_w_q[$];   // {addr, data} of each expected memory write
  logic [15:0] exp_o_q[$];   // {addr, data} of each expected result byte
  int n_cmp = 0;
  int n_err = 0;
  int start_hi = 0;
  int fin_cnt = 0;
  int ov_cnt = 0;
  logic stall_prev = 1'b0;
  logic [7:0] addr_prev, data_prev;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_wr_en) begin
        check_eq("wr_expected", 32'(exp_w_q.size() != 0), 32'd1);
        if (exp_w_q.size() != 0) check_eq("wr_addr_data", 32'({mem_addr, mem_wr_data}), 32'(exp_w_q.pop_front()));
      end
      if (stall_prev && out_valid) begin
        check_eq("stall_addr", 32'(mem_addr), 32'(addr_prev));
        check_eq("stall_data", 32'(out_data), 32'(data_prev));
      end
      if (out_valid && out_ready) begin
        check_eq("out_expected", 32'(exp_o_q.size() != 0), 32'd1);
        if (exp_o_q.size() != 0) check_eq("out_addr_data", 32'({mem_addr, out_data}), 32'(exp_o_q.pop_front()));
      end
      stall_prev = out_valid && !out_ready;
      addr_prev  = mem_addr;
      data_prev  = out_data;
      if (cpu_start) start_hi++;
      if (finished)  fin_cnt++;
      if (out_valid) ov_cnt++;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (all start and end just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic start_go();
    fin_cnt = 0; start_hi = 0; ov_cnt = 0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    check_eq("busy_after_go", 32'(busy), 32'd1);
  endtask

  task automatic load_bytes(input int n, input bit toggle);
    logic [7:0] b;
    bit tog = 1'b1;
    int g;
    for (int i = 0; i < n; i++) begin
      b = toggle ? 8'(i) : 8'($urandom_range(0, 255));
      exp_w_q.push_back({8'(LOAD_BASE + i), b});
      in_data = b;
      g = 0;
      forever begin
        in_valid = toggle ? tog : ($urandom_range(0, 3) != 0);
        tog = ~tog;
        @(negedge clk);
        if (in_valid && in_ready) break;
        g++;
        if (g > 20) begin
          check_eq("load_bound", 32'(g), 32'd0);
          in_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Waits for the start pulse to end; returns at the negedge of RUN cycle 1.
  task automatic wait_run_entry(output bit ok);
    bit seen = 1'b0;
    int g = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_start) seen = 1'b1;
      else if (seen) begin ok = 1'b1; return; end
      g++;
      if (g > 50) begin
        check_eq("run_entry_bound", 32'(g), 32'd0);
        return;
      end
    end
  endtask

  // Core finishes on RUN cycle d. stale: done already high from the start.
  task automatic run_phase(input int d, input bit stale, input bit poke_go);
    bit ok;
    cpu_done = stale;
    wait_run_entry(ok);
    if (!ok) return;
    for (int k = 1; k <= d; k++) begin
      cpu_done = (stale && k == 1) || (k == d);
      go = poke_go && (k == d / 2);
      if (k == d) check_eq("cnt_in_run", 32'(cycle_count), 32'(d - 1));
      @(posedge clk); #1;
      if (k < d) @(negedge clk);
    end
    cpu_done = 1'b0;
    go = 1'b0;
    check_eq("cnt_after_run", 32'(cycle_count), 32'(d));
    check_eq("start_width", 32'(start_hi), 32'(START_CYCLES));
  endtask

  task automatic drain_phase(input bit patterned, input int d);
    int hs = 0;
    int g = 0;
    int c = 0;
    for (int i = 0; i < RES_LEN; i++) exp_o_q.push_back({8'(RES_BASE + i), 8'(8'hA0 + i)});
    forever begin
      out_ready = patterned ? ((c % 4 == 0) || (c % 4 == 3)) : 1'($urandom_range(0, 1));
      c++;
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      if (hs == RES_LEN) break;
      g++;
      if (g > 1000) begin
        check_eq("drain_bound", 32'(hs), 32'(RES_LEN));
        exp_o_q.delete();
        out_ready = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    out_ready = 1'b1;   // a ready with nothing valid must not produce bytes
    @(negedge clk);
    check_eq("finished_on_idle", 32'(finished), 32'd1);
    check_eq("idle_after_drain", 32'(busy), 32'd0);
    check_eq("out_valid_idle", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("finished_once", 32'(fin_cnt), 32'd1);
    check_eq("cnt_held_idle", 32'(cycle_count), 32'(d));
    check_eq("out_q_empty", 32'(exp_o_q.size()), 32'd0);
    check_eq("wr_q_empty", 32'(exp_w_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"},      32'(busy), 32'd0);
    check_eq({tag, "_in_ready"},  32'(in_ready), 32'd0);
    check_eq({tag, "_wr_en"},     32'(mem_wr_en), 32'd0);
    check_eq({tag, "_cpu_start"}, 32'(cpu_start), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_finished"},  32'(finished), 32'd0);
    check_eq({tag, "_cnt"},       32'(cycle_count), 32'd0);
    check_eq({tag, "_addr"},      32'(mem_addr), 32'd0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int d;
    reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    cpu_done = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < RES_LEN; i++) mem[8'(RES_BASE + i)] = 8'(8'hA0 + i);

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    check_eq("reset_state", 32'(fsm_state), 32'(S_IDLE));
    reset = 1'b0;
    @(posedge clk); #1;

    // Run 1: counting bytes with toggled valid, stale done, patterned drain.
    start_go();
    load_bytes(LOAD_LEN, 1'b1);
    run_phase(2, 1'b1, 1'b0);
    drain_phase(1'b1, 2);

    // Run 2: random bytes, done on RUN cycle 100, go poked mid-RUN.
    start_go();
    load_bytes(LOAD_LEN, 1'b0);
    run_phase(100, 1'b0, 1'b1);
    drain_phase(1'b0, 100);

    // Run 3: reset in the middle of LOAD with a byte on offer.
    start_go();
    load_bytes(10, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    #2;
    reset = 1'b1;
    #1;
    check_zero_outputs("mid_load_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    check_eq("reset_flush_q", 32'(exp_w_q.size()), 32'd0);
    exp_w_q.delete();
    @(posedge clk); #1;
    start_go();
    load_bytes(LOAD_LEN, 1'b0);
    d = $urandom_range(3, 40);
    run_phase(d, 1'b0, 1'b0);
    drain_phase(1'b0, d);

`ifdef RUN_SEQUENCER_TIMEOUT_EN
    // Watchdog: done never comes.
    begin
      bit ok;
      int k;
      start_go();
      load_bytes(LOAD_LEN, 1'b0);
      cpu_done = 1'b0;
      wait_run_entry(ok);
      k = 0;
      while (busy && k < 200) begin
        k++;
        @(negedge clk);
      end
      check_eq("to_run_cycles", 32'(k), 32'(TO_CYCLES));
      check_eq("to_flag", 32'(timeout), 32'd1);
      check_eq("to_finished", 32'(finished), 32'd1);
      check_eq("to_cnt", 32'(cycle_count), 32'(TO_CYCLES));
      check_eq("to_no_drain", 32'(ov_cnt), 32'd0);
      @(posedge clk); #1;
      start_go();
      check_eq("to_cleared_by_go", 32'(timeout), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_w_q.delete();
    end
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
